// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares the RAM data port between the MEM stage (M) and
// the loader/debug port (L). M has priority. A starvation counter forces an
// L grant after STARVE_LIMIT consecutive M grants while L waits. Read data
// is routed back to the owner of the read one cycle after grant.
module rv32i_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4     // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    // MEM-stage requester
    input  logic        m_req,
    input  logic        m_we,
    input  logic [3:0]  m_be,
    input  logic [29:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_gnt,
    output logic        m_rvalid,
    output logic [31:0] m_rdata,
    output logic        mem_stall,
    // loader/debug requester
    input  logic        l_req,
    input  logic        l_we,
    input  logic [3:0]  l_be,
    input  logic [29:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    // RAM data port
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic {OWN_M = 1'b0, OWN_L = 1'b1} owner_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [29:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       rd_pend_q, rd_pend_d;
    owner_e     rd_owner_q, rd_owner_d;
    req_t       m_r, l_r, ram_r;

    assign m_r = '{we: m_we, be: m_be, addr: m_addr, wdata: m_wdata};
    assign l_r = '{we: l_we, be: l_be, addr: l_addr, wdata: l_wdata};

    // Grant decision: L wins when M is idle or L has waited long enough.
    always_comb begin
        l_gnt     = 1'b0;
        m_gnt     = 1'b0;
        mem_stall = 1'b0;
        if (!reset) begin
            l_gnt     = l_req & ((starve_q == LIMIT) | ~m_req);
            m_gnt     = m_req & ~l_gnt;
            mem_stall = m_req & ~m_gnt;
        end
    end

    // RAM port mux: granted requester drives the port, otherwise all zero.
    always_comb begin
        ram_r = '0;
        if (l_gnt)      ram_r = l_r;
        else if (m_gnt) ram_r = m_r;
    end

    assign ram_we    = ram_r.we;
    assign ram_be    = ram_r.be;
    assign ram_addr  = ram_r.addr;
    assign ram_wdata = ram_r.wdata;

    // Next-state for the starvation counter and the read tracker.
    always_comb begin
        starve_d   = starve_q;
        rd_pend_d  = (m_gnt & ~m_we) | (l_gnt & ~l_we);
        rd_owner_d = l_gnt ? OWN_L : OWN_M;
        if (l_gnt || !l_req)
            starve_d = 4'd0;
        else if (m_gnt && starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
    end

    // State registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q   <= 4'd0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_M;
        end else begin
            starve_q   <= starve_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Read return: only the owner sees data; reset suppresses a pending return.
    always_comb begin
        m_rvalid = 1'b0;
        l_rvalid = 1'b0;
        m_rdata  = '0;
        l_rdata  = '0;
        if (rd_pend_q && !reset) begin
            if (rd_owner_q == OWN_L) begin
                l_rvalid = 1'b1;
                l_rdata  = ram_rdata;
            end else begin
                m_rvalid = 1'b1;
                m_rdata  = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with STARVE_LIMIT = 4.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_rv32i_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt, m_rvalid, mem_stall;
    logic [31:0] m_rdata;
    logic        l_req, l_we;
    logic [3:0]  l_be;
    logic [29:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_rdata;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    rv32i_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .mem_stall(mem_stall),
        .l_req(l_req), .l_we(l_we), .l_be(l_be), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_req = 0; m_we = 0; m_be = 4'hF; m_addr = '0; m_wdata = '0;
        l_req = 0; l_we = 0; l_be = 4'hF; l_addr = '0; l_wdata = '0;
    endtask

    initial begin
        int exp_l;
        int prev_l;
        reset = 1; ram_rdata = '0;
        idle();

        // ---- reset state, with both requesting ----
        next_cyc();
        m_req = 1; l_req = 1; ram_rdata = 32'h1111_1111;
        #1;
        chk("rst_m_gnt", 32'(m_gnt), 0);
        chk("rst_l_gnt", 32'(l_gnt), 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_ram_be", 32'(ram_be), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_m_rvalid", 32'(m_rvalid), 0);
        chk("rst_m_rdata", m_rdata, 0);
        next_cyc();
        reset = 0; idle(); ram_rdata = '0;

        // ---- M read 0x10 ----
        next_cyc();
        m_req = 1; m_addr = 30'h10;
        #1;
        chk("mrd_m_gnt", 32'(m_gnt), 1);
        chk("mrd_l_gnt", 32'(l_gnt), 0);
        chk("mrd_ram_addr", 32'(ram_addr), 32'h10);
        chk("mrd_ram_we", 32'(ram_we), 0);
        chk("mrd_ram_be", 32'(ram_be), 32'hF);
        next_cyc();
        idle(); ram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("mrd_m_rvalid", 32'(m_rvalid), 1);
        chk("mrd_m_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("mrd_l_rvalid", 32'(l_rvalid), 0);
        chk("mrd_l_rdata", l_rdata, 0);
        chk("idle_ram_addr", 32'(ram_addr), 0);

        // ---- L write 0x20 ----
        next_cyc();
        l_req = 1; l_we = 1; l_be = 4'b0011; l_addr = 30'h20; l_wdata = 32'h1234_5678;
        #1;
        chk("lwr_l_gnt", 32'(l_gnt), 1);
        chk("lwr_m_gnt", 32'(m_gnt), 0);
        chk("lwr_ram_we", 32'(ram_we), 1);
        chk("lwr_ram_be", 32'(ram_be), 32'h3);
        chk("lwr_ram_addr", 32'(ram_addr), 32'h20);
        chk("lwr_ram_wdata", ram_wdata, 32'h1234_5678);
        next_cyc();
        idle(); ram_rdata = 32'hFFFF_FFFF;
        #1;
        chk("lwr_l_rvalid", 32'(l_rvalid), 0);
        chk("lwr_m_rvalid", 32'(m_rvalid), 0);
        chk("lwr_l_rdata", l_rdata, 0);
        chk("idle_ram_wdata", ram_wdata, 0);

        // ---- M write: no rvalid afterwards ----
        next_cyc();
        m_req = 1; m_we = 1; m_be = 4'b1000; m_addr = 30'h3; m_wdata = 32'hA5A5_0000;
        #1;
        chk("mwr_ram_we", 32'(ram_we), 1);
        chk("mwr_ram_wdata", ram_wdata, 32'hA5A5_0000);
        next_cyc();
        idle();
        #1;
        chk("mwr_m_rvalid", 32'(m_rvalid), 0);

        // ---- starvation: both read 12 cycles, L on cycles 5 and 10 ----
        prev_l = -1;
        for (int i = 1; i <= 12; i++) begin
            next_cyc();
            m_req = 1; l_req = 1; m_addr = 30'(i); l_addr = 30'(i);
            ram_rdata = 32'(i - 1);
            #1;
            exp_l = (i == 5 || i == 10) ? 1 : 0;
            chk($sformatf("stv_l_gnt_c%0d", i), 32'(l_gnt), 32'(exp_l));
            chk($sformatf("stv_m_gnt_c%0d", i), 32'(m_gnt), 32'(1 - exp_l));
            chk($sformatf("stv_stall_c%0d", i), 32'(mem_stall), 32'(exp_l));
            if (prev_l >= 0) begin
                chk($sformatf("stv_l_rvalid_c%0d", i), 32'(l_rvalid), 32'(prev_l));
                chk($sformatf("stv_m_rvalid_c%0d", i), 32'(m_rvalid), 32'(1 - prev_l));
                chk($sformatf("stv_rdata_c%0d", i), prev_l == 1 ? l_rdata : m_rdata, 32'(i - 1));
            end
            prev_l = exp_l;
        end
        next_cyc();
        idle(); ram_rdata = 32'h0000_00C0;
        #1;
        chk("stv_last_m_rvalid", 32'(m_rvalid), 1);
        chk("stv_last_m_rdata", m_rdata, 32'h0000_00C0);

        // ---- alternating single reads M then L ----
        next_cyc();
        m_req = 1; m_addr = 30'h1;
        #1;
        chk("alt_m_gnt", 32'(m_gnt), 1);
        next_cyc();
        idle(); l_req = 1; l_addr = 30'h2; ram_rdata = 32'hA;
        #1;
        chk("alt_l_gnt", 32'(l_gnt), 1);
        chk("alt_m_rvalid", 32'(m_rvalid), 1);
        chk("alt_m_rdata", m_rdata, 32'hA);
        chk("alt_l_rvalid0", 32'(l_rvalid), 0);
        next_cyc();
        idle(); ram_rdata = 32'hB;
        #1;
        chk("alt_l_rvalid", 32'(l_rvalid), 1);
        chk("alt_l_rdata", l_rdata, 32'hB);
        chk("alt_m_rvalid1", 32'(m_rvalid), 0);
        chk("alt_m_rdata1", m_rdata, 0);

        // ---- reset right after a read grant (counter at 3) ----
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            m_req = 1; l_req = 1;
        end
        #1;
        chk("rr_m_gnt", 32'(m_gnt), 1);
        next_cyc();
        reset = 1; ram_rdata = 32'h5555_5555;
        #1;
        chk("rr_m_rvalid", 32'(m_rvalid), 0);
        chk("rr_m_rdata", m_rdata, 0);
        chk("rr_m_gnt_rst", 32'(m_gnt), 0);
        chk("rr_stall_rst", 32'(mem_stall), 0);
        // counter cleared by reset: four M grants before the forced L
        for (int i = 1; i <= 5; i++) begin
            next_cyc();
            reset = 0;
            #1;
            if (i == 1) chk("rr_post_m_rvalid", 32'(m_rvalid), 0);
            chk($sformatf("rr_l_gnt_c%0d", i), 32'(l_gnt), (i == 5) ? 1 : 0);
        end
        next_cyc();
        idle(); m_req = 1; m_addr = 30'h30;
        #1;
        chk("rr_fresh_gnt", 32'(m_gnt), 1);
        next_cyc();
        idle(); ram_rdata = 32'hCAFE_F00D;
        #1;
        chk("rr_fresh_rvalid", 32'(m_rvalid), 1);
        chk("rr_fresh_rdata", m_rdata, 32'hCAFE_F00D);

        // ---- l_req high 3, low 2, high again: counter restarts ----
        for (int i = 1; i <= 10; i++) begin
            next_cyc();
            m_req = 1; l_req = (i == 4 || i == 5) ? 0 : 1;
            #1;
            chk($sformatf("drop_l_gnt_c%0d", i), 32'(l_gnt), (i == 10) ? 1 : 0);
            chk($sformatf("drop_stall_c%0d", i), 32'(mem_stall), (i == 10) ? 1 : 0);
        end

        // ---- counter at limit, l_req dropped: no forced grant afterwards ----
        for (int i = 1; i <= 6; i++) begin
            next_cyc();
            m_req = 1; l_req = (i == 5) ? 0 : 1;
            #1;
            chk($sformatf("lim_l_gnt_c%0d", i), 32'(l_gnt), 0);
            chk($sformatf("lim_m_gnt_c%0d", i), 32'(m_gnt), 1);
        end

        next_cyc();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
